wb_rr_arb2: RTL and testbench

Two-master round-robin arbiter sharing one generated Wishbone register slave, e.g. a CPU port and a config-sequencer port on the same register bank. Grants bus ownership for a whole `cyc` cycle and forwards the owner's pipelined Wishbone signals to the slave. Holds the non-owner in stall and returns slave responses only to the owner. Tracks outstanding transfers so an owner releasing early never leaks an ack to the next master.

---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/wb_rr_arb2_if.sv | 30 +++
 rtl/wb_arb_wdog.sv | 49 ++++
 rtl/wb_rr_arb2.sv | 169 ++++++++++++++++
 tb/tb_wb_rr_arb2.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and widths for the two-master Wishbone arbiter.
//   arb_state_t : arbiter FSM state (IDLE / BUSY / DRAIN)
//   OUTST_W     : width of the outstanding-transfer counter
//   STALE_W     : width of the saturating stale-response counter (watchdog build)
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    localparam int OUTST_W = 2;
    localparam int STALE_W = 2;

endpackage

// File: rtl/wb_rr_arb2_if.sv
// wb_rr_arb2_if: one pipelined Wishbone link (request + response side).
//   master modport : drives cyc/stb/we/adr/sel/dat_w, receives dat_r/ack/err/rty/stall
//   slave modport  : the mirror image
// adr carries the word address, i.e. byte-address bits [ADDR_W-1:2].
interface wb_rr_arb2_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_W-3:0]     adr;
    logic [DATA_W/8-1:0]   sel;
    logic [DATA_W-1:0]     dat_w;
    logic [DATA_W-1:0]     dat_r;
    logic                  ack;
    logic                  err;
    logic                  rty;
    logic                  stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack, err, rty, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, err, rty, stall
    );
endinterface

// File: rtl/wb_arb_wdog.sv
// wb_arb_wdog: response watchdog and stale-response tracker.
// Built into wb_rr_arb2 only when WB_ARB_TIMEOUT_EN is defined.
//   clk_i, rst_n_i : clock, async active-low reset
//   i_busy         : arbiter is in BUSY
//   i_outst_nz     : at least one transfer is outstanding
//   i_resp         : slave ack/err/rty this cycle
//   o_timeout      : one-cycle pulse, oldest outstanding transfer abandoned
//   o_stale_nz     : a late response for an abandoned transfer is still due
module wb_arb_wdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic i_busy,
    input  logic i_outst_nz,
    input  logic i_resp,
    output logic o_timeout,
    output logic o_stale_nz
);
    localparam int WD_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [WD_W-1:0]    r_cnt;
    logic [STALE_W-1:0] r_stale;
    logic               w_arm;

    // Counts only while something is owed and the slave stays silent.
    assign w_arm      = i_busy & i_outst_nz & ~i_resp;
    assign o_timeout  = w_arm & (r_cnt == WD_W'(TIMEOUT - 1));
    assign o_stale_nz = |r_stale;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt   <= '0;
            r_stale <= '0;
        end else begin
            if (!w_arm || o_timeout) r_cnt <= '0;
            else                     r_cnt <= r_cnt + 1'b1;

            // A timeout implies no response this cycle, so inc/dec never collide.
            if (o_timeout) begin
                if (r_stale != '1) r_stale <= r_stale + 1'b1;
            end else if (i_resp && r_stale != '0) begin
                r_stale <= r_stale - 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_rr_arb2.sv
// wb_rr_arb2: two-master round-robin arbiter in front of one pipelined
// Wishbone slave. Ownership lasts for a whole cyc; the non-owner is stalled
// and sees no responses. Responses still owed after the owner releases are
// drained and discarded so they never reach the next owner.
//   clk_i, rst_n_i : clock, async active-low reset
//   m0, m1         : master-facing links (slave modport)
//   s              : slave-facing link (master modport)
// Optional feature macro: WB_ARB_TIMEOUT_EN adds the response watchdog
// (wb_arb_wdog); without it mN.err only forwards s.err.
module wb_rr_arb2
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    wb_rr_arb2_if.slave   m0,
    wb_rr_arb2_if.slave   m1,
    wb_rr_arb2_if.master  s
);
    arb_state_t         r_state;
    logic               r_owner;
    logic               r_last;
    logic [OUTST_W-1:0] r_outst;
    logic [OUTST_W-1:0] w_outst_nxt;

    logic w_req0, w_req1, w_win, w_busy, w_own_cyc;
    logic w_resp, w_inc, w_dec, w_to, w_stale_nz;

    assign w_req0    = m0.cyc & m0.stb;
    assign w_req1    = m1.cyc & m1.stb;
    // On a tie the master that did not win last time gets the bus.
    assign w_win     = (w_req0 & w_req1) ? ~r_last : w_req1;
    assign w_busy    = (r_state == ST_BUSY);
    assign w_own_cyc = r_owner ? m1.cyc : m0.cyc;
    assign w_resp    = s.ack | s.err | s.rty;

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .i_busy     (w_busy),
        .i_outst_nz (r_outst != '0),
        .i_resp     (w_resp),
        .o_timeout  (w_to),
        .o_stale_nz (w_stale_nz)
    );
`else
    logic w_unused_to;
    assign w_unused_to = |TIMEOUT;   // TIMEOUT only matters with the watchdog
    assign w_to        = 1'b0;
    assign w_stale_nz  = 1'b0;
`endif

    // Slave side: the owner's request passes straight through in BUSY only.
    always_comb begin
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        s.adr   = '0;
        s.sel   = '0;
        s.dat_w = '0;
        if (w_busy) begin
            if (r_owner) begin
                s.cyc   = m1.cyc;
                s.stb   = m1.cyc & m1.stb;
                s.we    = m1.we;
                s.adr   = m1.adr;
                s.sel   = m1.sel;
                s.dat_w = m1.dat_w;
            end else begin
                s.cyc   = m0.cyc;
                s.stb   = m0.cyc & m0.stb;
                s.we    = m0.we;
                s.adr   = m0.adr;
                s.sel   = m0.sel;
                s.dat_w = m0.dat_w;
            end
        end
    end

    // Responses belonging to an abandoned (timed-out) transfer are swallowed.
    logic              w_ack_f, w_err_f, w_rty_f;
    logic [DATA_W-1:0] w_dat_f;
    assign w_ack_f = s.ack & ~w_stale_nz;
    assign w_err_f = (s.err & ~w_stale_nz) | w_to;
    assign w_rty_f = s.rty & ~w_stale_nz;
    assign w_dat_f = w_stale_nz ? '0 : s.dat_r;

    always_comb begin
        m0.stall = w_req0;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.rty   = 1'b0;
        m0.dat_r = '0;
        if (w_busy && !r_owner) begin
            m0.stall = s.stall;
            m0.ack   = w_ack_f;
            m0.err   = w_err_f;
            m0.rty   = w_rty_f;
            m0.dat_r = w_dat_f;
        end
    end

    always_comb begin
        m1.stall = w_req1;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.rty   = 1'b0;
        m1.dat_r = '0;
        if (w_busy && r_owner) begin
            m1.stall = s.stall;
            m1.ack   = w_ack_f;
            m1.err   = w_err_f;
            m1.rty   = w_rty_f;
            m1.dat_r = w_dat_f;
        end
    end

    // Outstanding transfers: accepted strobes minus responses (or timeouts).
    // Late responses to abandoned transfers were already subtracted at timeout.
    assign w_inc = s.stb & ~s.stall;
    assign w_dec = (w_resp & ~w_stale_nz & (r_outst != '0)) | w_to;

    always_comb begin
        w_outst_nxt = r_outst;
        if (w_inc && !w_dec) begin
            if (r_outst != '1) w_outst_nxt = r_outst + 1'b1;
        end else if (!w_inc && w_dec) begin
            w_outst_nxt = r_outst - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;    // m0 wins the first tie
            r_outst <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Use the post-update count so a final ack in the release
                    // cycle goes straight back to IDLE.
                    if (!w_own_cyc)
                        r_state <= (w_outst_nxt == '0) ? ST_IDLE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_outst_nxt == '0) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    a_outst_no_wrap: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(w_inc && !w_dec && r_outst == '1));

endmodule

// File: tb/tb_wb_rr_arb2.sv
`timescale 1ns/1ps
module tb_wb_rr_arb2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_rr_arb2_if #(.ADDR_W(3), .DATA_W(32)) m0_if ();
    wb_rr_arb2_if #(.ADDR_W(3), .DATA_W(32)) m1_if ();
    wb_rr_arb2_if #(.ADDR_W(3), .DATA_W(32)) s_if ();

    wb_rr_arb2 #(.ADDR_W(3), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if)
    );

    // Two-word register slave, one transfer in flight, ack after ack_dly+1 cycles.
    logic [31:0] sregs [2];
    logic        pend;
    int          dly;
    int          ack_dly;
    logic [31:0] rdat;

    assign s_if.stall = 1'b0;
    assign s_if.err   = 1'b0;
    assign s_if.rty   = 1'b0;
    assign s_if.ack   = pend && (dly == 0);
    assign s_if.dat_r = (pend && (dly == 0)) ? rdat : 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            dly  <= 0;
            rdat <= 32'h0;
        end else begin
            if (pend && dly > 0) dly <= dly - 1;
            else if (pend)       pend <= 1'b0;
            if (s_if.cyc && s_if.stb) begin
                pend <= 1'b1;
                dly  <= ack_dly;
                if (s_if.we) begin
                    sregs[s_if.adr] <= s_if.dat_w;
                    rdat            <= 32'h0;
                end else begin
                    rdat <= sregs[s_if.adr];
                end
            end
        end
    end

    typedef struct packed {
        logic        cyc, stb, we;
        logic [0:0]  adr;
        logic [31:0] dat;
    } min_t;

    typedef struct packed {
        logic        s_cyc, s_stb, s_we;
        logic [0:0]  s_adr;
        logic [31:0] s_dat;
        logic        m0_stall, m0_ack, m0_err;
        logic [31:0] m0_dat;
        logic        m1_stall, m1_ack, m1_err;
        logic [31:0] m1_dat;
    } out_t;

    typedef struct {
        min_t a;
        min_t b;
        out_t e;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // ctl = {cyc, stb, we, adr}
    function automatic min_t mi(input logic [3:0] ctl, input logic [31:0] d);
        return min_t'({ctl, d});
    endfunction

    // sc = {s_cyc, s_stb, s_we, s_adr}; fN = {stall, ack, err}
    function automatic out_t mo(input logic [3:0] sc, input logic [31:0] sd,
                                input logic [2:0] f0, input logic [31:0] d0,
                                input logic [2:0] f1, input logic [31:0] d1);
        return out_t'({sc, sd, f0, d0, f1, d1});
    endfunction

    function automatic out_t act();
        return out_t'({s_if.cyc, s_if.stb, s_if.we, s_if.adr, s_if.dat_w,
                       m0_if.stall, m0_if.ack, m0_if.err, m0_if.dat_r,
                       m1_if.stall, m1_if.ack, m1_if.err, m1_if.dat_r});
    endfunction

    task automatic drive(input min_t a, input min_t b);
        m0_if.cyc = a.cyc; m0_if.stb = a.stb; m0_if.we = a.we;
        m0_if.adr = a.adr; m0_if.dat_w = a.dat; m0_if.sel = 4'hF;
        m1_if.cyc = b.cyc; m1_if.stb = b.stb; m1_if.we = b.we;
        m1_if.adr = b.adr; m1_if.dat_w = b.dat; m1_if.sel = 4'hF;
    endtask

    task automatic chk(input string nm, input out_t e);
        out_t a;
        a = act();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic step(input string nm, input min_t a, input min_t b, input out_t e);
        @(negedge clk);
        drive(a, b);
        #1;
        chk(nm, e);
    endtask

    vec_t vecs [16];

    initial begin
        min_t IDL, HOLD, W0_15, W1_2A, W0_77, R0, R1;
        out_t Z;
        IDL   = '0;
        HOLD  = mi(4'b1000, 32'h0);
        W0_15 = mi(4'b1110, 32'h15);
        W1_2A = mi(4'b1111, 32'h2A);
        W0_77 = mi(4'b1110, 32'h77);
        R0    = mi(4'b1100, 32'h0);
        R1    = mi(4'b1101, 32'h0);
        Z     = '0;

        // Tie from reset (m0 first), m1 after one idle cycle, second tie to m0,
        // write/readback of 0x15 and 0x2A.
        vecs[0]  = '{W0_15, W1_2A, mo(4'b0000, 32'h0,  3'b100, 32'h0,  3'b100, 32'h0)};
        vecs[1]  = '{W0_15, W1_2A, mo(4'b1110, 32'h15, 3'b000, 32'h0,  3'b100, 32'h0)};
        vecs[2]  = '{HOLD,  W1_2A, mo(4'b1000, 32'h0,  3'b010, 32'h0,  3'b100, 32'h0)};
        vecs[3]  = '{IDL,   W1_2A, mo(4'b0000, 32'h0,  3'b000, 32'h0,  3'b100, 32'h0)};
        vecs[4]  = '{IDL,   W1_2A, mo(4'b0000, 32'h0,  3'b000, 32'h0,  3'b100, 32'h0)};
        vecs[5]  = '{IDL,   W1_2A, mo(4'b1111, 32'h2A, 3'b000, 32'h0,  3'b000, 32'h0)};
        vecs[6]  = '{IDL,   HOLD,  mo(4'b1000, 32'h0,  3'b000, 32'h0,  3'b010, 32'h0)};
        vecs[7]  = '{IDL,   IDL,   Z};
        vecs[8]  = '{R0,    R1,    mo(4'b0000, 32'h0,  3'b100, 32'h0,  3'b100, 32'h0)};
        vecs[9]  = '{R0,    R1,    mo(4'b1100, 32'h0,  3'b000, 32'h0,  3'b100, 32'h0)};
        vecs[10] = '{HOLD,  R1,    mo(4'b1000, 32'h0,  3'b010, 32'h15, 3'b100, 32'h0)};
        vecs[11] = '{IDL,   R1,    mo(4'b0000, 32'h0,  3'b000, 32'h0,  3'b100, 32'h0)};
        vecs[12] = '{IDL,   R1,    mo(4'b0000, 32'h0,  3'b000, 32'h0,  3'b100, 32'h0)};
        vecs[13] = '{IDL,   R1,    mo(4'b1101, 32'h0,  3'b000, 32'h0,  3'b000, 32'h0)};
        vecs[14] = '{IDL,   HOLD,  mo(4'b1000, 32'h0,  3'b000, 32'h0,  3'b010, 32'h2A)};
        vecs[15] = '{IDL,   IDL,   Z};

        ack_dly = 0;
        drive(IDL, IDL);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("reset", Z);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            step($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].e);

        // m1 releases with a read outstanding; m0 waits through DRAIN.
        ack_dly = 2;
        step("drn_grant", IDL,   R1,  mo(4'b0000, 32'h0, 3'b000, 32'h0, 3'b100, 32'h0));
        step("drn_xfer",  W0_77, R1,  mo(4'b1101, 32'h0, 3'b100, 32'h0, 3'b000, 32'h0));
        step("drn_rel",   W0_77, IDL, mo(4'b0000, 32'h0, 3'b100, 32'h0, 3'b000, 32'h0));
        step("drn_wait",  W0_77, IDL, mo(4'b0000, 32'h0, 3'b100, 32'h0, 3'b000, 32'h0));
        step("drn_ack",   W0_77, IDL, mo(4'b0000, 32'h0, 3'b100, 32'h0, 3'b000, 32'h0));
        step("drn_idle",  W0_77, IDL, mo(4'b0000, 32'h0, 3'b100, 32'h0, 3'b000, 32'h0));
        ack_dly = 0;
        step("drn_m0",    W0_77, IDL, mo(4'b1110, 32'h77, 3'b000, 32'h0, 3'b000, 32'h0));
        // Final ack in the same cycle m0 drops cyc: delivered, straight to IDLE.
        step("last_ack",  IDL,   IDL, mo(4'b0000, 32'h0, 3'b010, 32'h0, 3'b000, 32'h0));
        step("post_idle", IDL,   R0,  mo(4'b0000, 32'h0, 3'b000, 32'h0, 3'b100, 32'h0));
        step("post_busy", IDL,   R0,  mo(4'b1100, 32'h0, 3'b000, 32'h0, 3'b000, 32'h0));
        step("post_rd",   IDL,   HOLD, mo(4'b1000, 32'h0, 3'b000, 32'h0, 3'b010, 32'h77));
        step("post_end",  IDL,   IDL, Z);

        // Reset while BUSY with one read outstanding.
        ack_dly = 3;
        step("rst_grant", R0, IDL, mo(4'b0000, 32'h0, 3'b100, 32'h0, 3'b000, 32'h0));
        step("rst_xfer",  R0, IDL, mo(4'b1100, 32'h0, 3'b000, 32'h0, 3'b000, 32'h0));
        @(negedge clk);
        drive(HOLD, IDL);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid", Z);
        @(negedge clk);
        drive(IDL, R1);
        rst_n = 1'b1;
        ack_dly = 0;
        #1 chk("rst_idle", mo(4'b0000, 32'h0, 3'b000, 32'h0, 3'b100, 32'h0));
        step("rst_m1",    IDL, R1,   mo(4'b1101, 32'h0, 3'b000, 32'h0, 3'b000, 32'h0));
        step("rst_m1ack", IDL, HOLD, mo(4'b1000, 32'h0, 3'b000, 32'h0, 3'b010, 32'h2A));
        step("rst_end",   IDL, IDL,  Z);

`ifdef WB_ARB_TIMEOUT_EN
        // Slave withholds the ack; watchdog fires on the 4th silent cycle,
        // the late ack is swallowed, the next transfer acks normally.
        ack_dly = 10;
        step("to_grant", R1, IDL, mo(4'b0000, 32'h0, 3'b100, 32'h0, 3'b000, 32'h0));
        step("to_xfer",  R1, IDL, mo(4'b1101, 32'h0, 3'b000, 32'h0, 3'b000, 32'h0));
        for (int i = 0; i < 3; i++)
            step($sformatf("to_wait%0d", i), HOLD, IDL, mo(4'b1000, 32'h0, 3'b000, 32'h0, 3'b000, 32'h0));
        step("to_err",   HOLD, IDL, mo(4'b1000, 32'h0, 3'b001, 32'h0, 3'b000, 32'h0));
        for (int i = 0; i < 9; i++)
            step($sformatf("to_swallow%0d", i), HOLD, IDL, mo(4'b1000, 32'h0, 3'b000, 32'h0, 3'b000, 32'h0));
        ack_dly = 0;
        step("to_next",  R1,   IDL, mo(4'b1101, 32'h0, 3'b000, 32'h0, 3'b000, 32'h0));
        step("to_ack",   HOLD, IDL, mo(4'b1000, 32'h0, 3'b010, 32'h2A, 3'b000, 32'h0));
        step("to_end",   IDL,  IDL, Z);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
